// File: rtl/m_tx_pkg.sv
// Shared definitions for the Manchester transmitter path: scheduler states and
// default buffer/frame sizing.
package m_tx_pkg;

    localparam int unsigned DefBufDepth    = 256;
    localparam int unsigned DefMaxFrameLen = 64;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StStream,
        StCommit
    } sched_state_e;

    function automatic logic len_legal(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/m_rr_arbiter2.sv
// Two-requester round-robin pick. The pointer names the requester preferred on a
// tie and moves to the non-owner whenever advance_i is pulsed.
module m_rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       owner_i,
    output logic [1:0] pick_o
);

    logic ptr_q;

    always_comb begin
        pick_o = 2'b00;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = ptr_q ? 2'b10 : 2'b01;
            default: pick_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else if (advance_i) begin
            ptr_q <= ~owner_i;
        end
    end

endmodule

// File: rtl/m_tx_frame_scheduler.sv
// Admits whole frames from two byte-stream sources into the transmitter buffer,
// streams them byte by byte and pulses a commit after each frame.
module m_tx_frame_scheduler
    import m_tx_pkg::*;
#(
    parameter int unsigned BUF_DEPTH     = DefBufDepth,
    parameter int unsigned MAX_FRAME_LEN = DefMaxFrameLen
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req_valid,
    input  logic [15:0] i_req_data,
    input  logic [1:0]  i_req_last,
    input  logic [15:0] i_req_len,
    output logic [1:0]  o_req_ready,
    input  logic [7:0]  i_tx_data_count,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_data_we,
    output logic        o_tx_frame_commit,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic        o_err_len
);

    sched_state_e state_q;
    logic [1:0]   grant_q;
    logic [1:0]   drop_q;
    logic [7:0]   len_q;
    logic [7:0]   cnt_q;
    logic [7:0]   tx_data_q;
    logic         we_q;
    logic         commit_q;
    logic         busy_q;
    logic         err_q;

    logic [1:0]   pick;
    logic         win_idx;
    logic [7:0]   win_len;
    logic         win_bad;
    logic         arb;
    logic         advance;
    logic         adv_owner;
    logic [8:0]   free;
    logic         own;
    logic         own_valid;
    logic         own_last;
    logic [7:0]   own_data;
    logic         hs;
    logic [7:0]   cnt_inc;
    logic         len_hit;

    always_comb begin
        win_idx   = pick[1];
        win_len   = win_idx ? i_req_len[15:8] : i_req_len[7:0];
        win_bad   = !len_legal(win_len, MAX_FRAME_LEN);
        // A pending discard beat must be consumed before arbitrating again.
        arb       = (state_q == StIdle) && (drop_q == 2'b00) && (i_req_valid != 2'b00);
        advance   = (arb && win_bad) || (state_q == StCommit);
        adv_owner = (state_q == StCommit) ? grant_q[1] : win_idx;
        free      = 9'(BUF_DEPTH) - {1'b0, i_tx_data_count};
        own       = grant_q[1];
        own_valid = (i_req_valid & grant_q) != 2'b00;
        own_last  = own ? i_req_last[1] : i_req_last[0];
        own_data  = own ? i_req_data[15:8] : i_req_data[7:0];
        hs        = (state_q == StStream) && own_valid;
        cnt_inc   = cnt_q + 8'd1;
        len_hit   = (cnt_inc == len_q);
    end

    m_rr_arbiter2 u_arb (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .req_i     (i_req_valid),
        .advance_i (advance),
        .owner_i   (adv_owner),
        .pick_o    (pick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            drop_q    <= 2'b00;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            tx_data_q <= 8'd0;
            we_q      <= 1'b0;
            commit_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q     <= 1'b0;
            commit_q <= 1'b0;
            drop_q   <= 2'b00;
            case (state_q)
                StIdle: begin
                    if (arb) begin
                        if (win_bad) begin
                            drop_q <= pick;
                            err_q  <= 1'b1;
                        end else begin
                            grant_q <= pick;
                            len_q   <= win_len;
                            busy_q  <= 1'b1;
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    // Hold the grant until the whole frame fits; no rotation here.
                    if ({1'b0, len_q} <= free) begin
                        cnt_q   <= 8'd0;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (hs) begin
                        tx_data_q <= own_data;
                        we_q      <= 1'b1;
                        cnt_q     <= cnt_inc;
                        if (len_hit || own_last) begin
                            if (len_hit != own_last) begin
                                err_q <= 1'b1;
                            end
                            state_q <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    commit_q <= 1'b1;
                    grant_q  <= 2'b00;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_req_ready       = ((state_q == StStream) ? grant_q : 2'b00) | drop_q;
    assign o_tx_data         = tx_data_q;
    assign o_tx_data_we      = we_q;
    assign o_tx_frame_commit = commit_q;
    assign o_grant           = grant_q;
    assign o_busy            = busy_q;
    assign o_err_len         = err_q;

endmodule

// File: tb/tb_m_tx_frame_scheduler.sv
// Bench for m_tx_frame_scheduler: queue-driven requesters, a byte/commit monitor
// and a frame-level round-robin model.
module tb_m_tx_frame_scheduler;

    localparam int MaxLen = 64;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
        int         gap;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [15:0] req_len;
    logic [1:0]  req_ready;
    logic [7:0]  tx_count;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        tx_commit;
    logic [1:0]  grant;
    logic        busy;
    logic        err_len;

    m_tx_frame_scheduler dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .i_req_last        (req_last),
        .i_req_len         (req_len),
        .o_req_ready       (req_ready),
        .i_tx_data_count   (tx_count),
        .o_tx_data         (tx_data),
        .o_tx_data_we      (tx_we),
        .o_tx_frame_commit (tx_commit),
        .o_grant           (grant),
        .o_busy            (busy),
        .o_err_len         (err_len)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    beat_t      q0[$];
    beat_t      q1[$];
    int         head_gap[2];
    int         acc_cyc[$];
    logic [7:0] wr_bytes[$];
    int         wr_cyc[$];
    int         cm_cyc[$];
    int         viol = 0;
    logic [7:0] exp_bytes[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (tx_we) begin
            wr_bytes.push_back(tx_data);
            wr_cyc.push_back(cyc);
            if (grant == 2'b00) viol = viol + 1;
        end
        if (tx_commit) cm_cyc.push_back(cyc);
    end

    function automatic int qsize(input int r);
        return (r == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t head(input int r);
        return (r == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int diff_bytes();
        int bad = 0;
        if (wr_bytes.size() != exp_bytes.size()) return 1;
        foreach (exp_bytes[i]) if (wr_bytes[i] !== exp_bytes[i]) bad++;
        return bad;
    endfunction

    task automatic push_beat(input int r, input logic [7:0] d, input logic l,
                             input logic [7:0] n, input int gap);
        beat_t b;
        b.data = d; b.last = l; b.len = n; b.gap = gap;
        if (r == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); wr_bytes.delete(); wr_cyc.delete(); cm_cyc.delete();
        exp_bytes.delete();
        viol = 0;
    endtask

    task automatic drive_inputs();
        logic [1:0]  v;
        logic [1:0]  l;
        logic [15:0] d;
        logic [15:0] n;
        beat_t       b;
        v = '0; l = '0; d = '0; n = '0;
        for (int r = 0; r < 2; r++) begin
            if (qsize(r) > 0 && head_gap[r] == 0) begin
                b = head(r);
                v[r] = 1'b1;
                l[r] = b.last;
                d[8*r +: 8] = b.data;
                n[8*r +: 8] = b.len;
            end
        end
        req_valid = v; req_last = l; req_data = d; req_len = n;
    endtask

    // One clock: drive at the falling edge, retire handshakes at the rising edge.
    task automatic step();
        logic [1:0] fire;
        drive_inputs();
        fire = req_valid & req_ready;
        if (fire != 2'b00) acc_cyc.push_back(cyc);
        @(posedge clk);
        for (int r = 0; r < 2; r++) begin
            if (fire[r]) begin
                if (r == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                head_gap[r] = (qsize(r) > 0) ? head(r).gap : 0;
            end else if (qsize(r) > 0 && head_gap[r] > 0) begin
                head_gap[r] = head_gap[r] - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total_cnt++;
            $display("FAIL run_timeout: still busy after %0d cycles (q0=%0d q1=%0d)",
                     n, q0.size(), q1.size());
            q0.delete(); q1.delete();
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete(); q1.delete();
        head_gap[0] = 0; head_gap[1] = 0;
        repeat (2) step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({tx_data, tx_we, tx_commit, grant, busy, err_len, req_ready} !== 16'h0)
            $display("FAIL reset_outputs: got %h want 0",
                     {tx_data, tx_we, tx_commit, grant, busy, err_len, req_ready});
        else pass_cnt++;
    endtask

    task automatic test_single();
        int c0;
        int bad = 0;
        do_reset();
        tx_count = 8'd0;
        push_beat(0, 8'hA1, 1'b0, 8'd3, 0);
        push_beat(0, 8'hA2, 1'b0, 8'd3, 0);
        push_beat(0, 8'hA3, 1'b1, 8'd3, 0);
        exp_bytes = '{8'hA1, 8'hA2, 8'hA3};
        c0 = cyc;
        run_done(50);
        total_cnt++;
        if (diff_bytes() !== 0) $display("FAIL single_bytes: got %p want %p", wr_bytes, exp_bytes);
        else pass_cnt++;
        total_cnt++;
        if ((acc_cyc.size() == 3 ? acc_cyc[0] : -1) !== c0 + 2)
            $display("FAIL single_first_accept: got %0d want %0d",
                     acc_cyc.size() == 3 ? acc_cyc[0] : -1, c0 + 2);
        else pass_cnt++;
        if (acc_cyc.size() != 3 || wr_cyc.size() != 3) bad = 1;
        else foreach (acc_cyc[i]) if (wr_cyc[i] != acc_cyc[i] + 1) bad++;
        total_cnt++;
        if (bad !== 0) $display("FAIL single_write_latency: got %0d late writes want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (cm_cyc.size() !== 1) $display("FAIL single_commits: got %0d want 1", cm_cyc.size());
        else pass_cnt++;
        total_cnt++;
        if ((cm_cyc.size() == 1 && acc_cyc.size() == 3 ? cm_cyc[0] - acc_cyc[2] : -1) !== 2)
            $display("FAIL single_commit_latency: got %0d want 2",
                     cm_cyc.size() == 1 && acc_cyc.size() == 3 ? cm_cyc[0] - acc_cyc[2] : -1);
        else pass_cnt++;
        total_cnt++;
        if (err_len !== 1'b0) $display("FAIL single_err: got %b want 0", err_len);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        do_reset();
        push_beat(0, 8'h10, 1'b0, 8'd2, 0);
        push_beat(0, 8'h11, 1'b1, 8'd2, 0);
        push_beat(1, 8'h20, 1'b0, 8'd2, 0);
        push_beat(1, 8'h21, 1'b1, 8'd2, 0);
        exp_bytes = '{8'h10, 8'h11, 8'h20, 8'h21};
        run_done(60);
        total_cnt++;
        if (diff_bytes() !== 0) $display("FAIL tie_order: got %p want %p", wr_bytes, exp_bytes);
        else pass_cnt++;
        total_cnt++;
        if (cm_cyc.size() !== 2) $display("FAIL tie_commits: got %0d want 2", cm_cyc.size());
        else pass_cnt++;
    endtask

    task automatic test_check_hold();
        int c;
        do_reset();
        tx_count = 8'd250;
        for (int i = 0; i < 10; i++) begin
            push_beat(0, 8'(8'h40 + i), (i == 9), 8'd10, 0);
            exp_bytes.push_back(8'(8'h40 + i));
        end
        repeat (6) step();
        total_cnt++;
        if (acc_cyc.size() !== 0) $display("FAIL hold_no_accept: got %0d want 0", acc_cyc.size());
        else pass_cnt++;
        total_cnt++;
        if ({grant, req_ready, busy} !== 5'b01_00_1)
            $display("FAIL hold_state: got %b want 01001", {grant, req_ready, busy});
        else pass_cnt++;
        tx_count = 8'd246;
        c = cyc;
        run_done(80);
        total_cnt++;
        if ((acc_cyc.size() > 0 ? acc_cyc[0] : -1) !== c + 1)
            $display("FAIL hold_release: got %0d want %0d", acc_cyc.size() > 0 ? acc_cyc[0] : -1, c + 1);
        else pass_cnt++;
        total_cnt++;
        if (diff_bytes() !== 0) $display("FAIL hold_bytes: got %p want %p", wr_bytes, exp_bytes);
        else pass_cnt++;
        tx_count = 8'd0;
    endtask

    task automatic test_errors();
        // last arrives before the declared length
        do_reset();
        push_beat(0, 8'hB1, 1'b0, 8'd3, 0);
        push_beat(0, 8'hB2, 1'b1, 8'd3, 0);
        exp_bytes = '{8'hB1, 8'hB2};
        run_done(50);
        total_cnt++;
        if (diff_bytes() !== 0 || cm_cyc.size() != 1 || err_len !== 1'b1)
            $display("FAIL early_last: got bytes %p commits %0d err %b want %p 1 1",
                     wr_bytes, cm_cyc.size(), err_len, exp_bytes);
        else pass_cnt++;
        // zero length is discarded
        do_reset();
        push_beat(0, 8'h55, 1'b1, 8'd0, 0);
        run_done(50);
        total_cnt++;
        if (acc_cyc.size() != 1 || wr_bytes.size() != 0 || cm_cyc.size() != 0 || err_len !== 1'b1)
            $display("FAIL len_zero: got acc %0d wr %0d commits %0d err %b want 1 0 0 1",
                     acc_cyc.size(), wr_bytes.size(), cm_cyc.size(), err_len);
        else pass_cnt++;
        // length reached before last: remainder becomes a new frame
        do_reset();
        push_beat(0, 8'hC1, 1'b0, 8'd2, 0);
        push_beat(0, 8'hC2, 1'b0, 8'd2, 0);
        push_beat(0, 8'hC3, 1'b1, 8'd2, 0);
        exp_bytes = '{8'hC1, 8'hC2, 8'hC3};
        run_done(60);
        total_cnt++;
        if (diff_bytes() !== 0 || cm_cyc.size() != 2 || err_len !== 1'b1)
            $display("FAIL late_last: got bytes %p commits %0d err %b want %p 2 1",
                     wr_bytes, cm_cyc.size(), err_len, exp_bytes);
        else pass_cnt++;
        // oversize length on r0 wins the tie, is dropped, and the pointer moves to r1
        do_reset();
        push_beat(0, 8'h99, 1'b1, 8'(MaxLen + 1), 0);
        push_beat(0, 8'hE1, 1'b1, 8'd1, 0);
        push_beat(1, 8'hF1, 1'b1, 8'd1, 0);
        exp_bytes = '{8'hF1, 8'hE1};
        run_done(60);
        total_cnt++;
        if (diff_bytes() !== 0 || cm_cyc.size() != 2 || err_len !== 1'b1)
            $display("FAIL oversize: got bytes %p commits %0d err %b want %p 2 1",
                     wr_bytes, cm_cyc.size(), err_len, exp_bytes);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        push_beat(0, 8'h30, 1'b0, 8'd4, 0);
        push_beat(0, 8'h31, 1'b0, 8'd4, 5);
        push_beat(0, 8'h32, 1'b0, 8'd4, 0);
        push_beat(0, 8'h33, 1'b1, 8'd4, 0);
        push_beat(1, 8'h50, 1'b0, 8'd2, 0);
        push_beat(1, 8'h51, 1'b1, 8'd2, 0);
        exp_bytes = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h50, 8'h51};
        run_done(80);
        total_cnt++;
        if (diff_bytes() !== 0) $display("FAIL stall_order: got %p want %p", wr_bytes, exp_bytes);
        else pass_cnt++;
        total_cnt++;
        if ((wr_cyc.size() >= 2 ? wr_cyc[1] - wr_cyc[0] : -1) !== 6)
            $display("FAIL stall_gap: got %0d want 6", wr_cyc.size() >= 2 ? wr_cyc[1] - wr_cyc[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        push_beat(0, 8'h60, 1'b0, 8'd2, 0);
        push_beat(0, 8'h61, 1'b1, 8'd2, 0);
        run_done(50);
        clear_logs();
        for (int i = 0; i < 8; i++) push_beat(0, 8'(8'h70 + i), (i == 7), 8'd8, 0);
        while (acc_cyc.size() < 3 && n < 40) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        total_cnt++;
        if ({tx_data, tx_we, tx_commit, grant, busy, err_len, req_ready} !== 16'h0)
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {tx_data, tx_we, tx_commit, grant, busy, err_len, req_ready});
        else pass_cnt++;
        q0.delete(); q1.delete();
        head_gap[0] = 0; head_gap[1] = 0;
        step();
        rst = 1'b0;
        clear_logs();
        push_beat(0, 8'h80, 1'b0, 8'd2, 0);
        push_beat(0, 8'h81, 1'b1, 8'd2, 0);
        push_beat(1, 8'h90, 1'b0, 8'd2, 0);
        push_beat(1, 8'h91, 1'b1, 8'd2, 0);
        exp_bytes = '{8'h80, 8'h81, 8'h90, 8'h91};
        run_done(60);
        total_cnt++;
        if (diff_bytes() !== 0) $display("FAIL reset_mid_tie: got %p want %p", wr_bytes, exp_bytes);
        else pass_cnt++;
    endtask

    // Model: both sources keep frames queued, so whole frames alternate starting
    // at requester 0, and the longer queue drains alone at the end.
    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int         nf[2];
            int         lens0[$];
            int         lens1[$];
            logic [7:0] b0[$];
            logic [7:0] b1[$];
            int         turn = 0;
            do_reset();
            tx_count = 8'($urandom_range(0, 256 - MaxLen));
            nf[0] = $urandom_range(1, 4);
            nf[1] = $urandom_range(0, 4);
            for (int r = 0; r < 2; r++) begin
                for (int f = 0; f < nf[r]; f++) begin
                    int len = $urandom_range(1, MaxLen);
                    if (r == 0) lens0.push_back(len); else lens1.push_back(len);
                    for (int k = 0; k < len; k++) begin
                        logic [7:0] d = 8'($urandom);
                        int gap = (k > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
                        push_beat(r, d, (k == len - 1), 8'(len), gap);
                        if (r == 0) b0.push_back(d); else b1.push_back(d);
                    end
                end
            end
            while (lens0.size() > 0 || lens1.size() > 0) begin
                if ((turn == 0 && lens0.size() > 0) || lens1.size() == 0) begin
                    int len = lens0.pop_front();
                    for (int k = 0; k < len; k++) exp_bytes.push_back(b0.pop_front());
                    turn = 1;
                end else begin
                    int len = lens1.pop_front();
                    for (int k = 0; k < len; k++) exp_bytes.push_back(b1.pop_front());
                    turn = 0;
                end
            end
            run_done(2000);
            total_cnt++;
            if (diff_bytes() !== 0)
                $display("FAIL rand_bytes[%0d]: got %0d bytes (%0d differ) want %0d",
                         it, wr_bytes.size(), diff_bytes(), exp_bytes.size());
            else pass_cnt++;
            total_cnt++;
            if (cm_cyc.size() !== nf[0] + nf[1])
                $display("FAIL rand_commits[%0d]: got %0d want %0d", it, cm_cyc.size(), nf[0] + nf[1]);
            else pass_cnt++;
            total_cnt++;
            if ({err_len, 32'(viol)} !== 33'd0)
                $display("FAIL rand_err_viol[%0d]: got err %b ungranted writes %0d want 0 0",
                         it, err_len, viol);
            else pass_cnt++;
        end
        tx_count = 8'd0;
    endtask

    initial begin
        rst = 1'b1;
        tx_count = 8'd0;
        req_valid = '0; req_data = '0; req_last = '0; req_len = '0;
        head_gap[0] = 0; head_gap[1] = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_tie();
        test_check_hold();
        test_errors();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/m_tx_frame_scheduler.md
# m_tx_frame_scheduler

Frame scheduler in front of the Manchester transmitter. It arbitrates round-robin between two byte-stream frame sources. It admits a frame only when the transmitter's circular buffer has room for the whole frame, then streams the frame's bytes into the transmitter's byte write port. After the last byte it issues one frame-commit pulse, which advances the transmitter's frame counter and starts preamble/data transmission.

## Interface
Parameters:
- BUF_DEPTH, 256: byte capacity of the transmitter circular buffer.
- MAX_FRAME_LEN, 64: largest legal frame length in bytes (1..255).

Ports:
- i_clk  in  1  single clock, shared with the transmitter's i_clk.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  2  per-requester beat valid.
- i_req_data  in  16  requester r drives byte on [8r+7:8r].
- i_req_last  in  2  final byte of the frame.
- i_req_len  in  16  requester r drives frame length on [8r+7:8r]; held stable while valid.
- o_req_ready  out  2  beat accepted when valid&ready.
- i_tx_data_count  in  8  current transmitter buffer fill level, in bytes.
- o_tx_data  out  8  byte to the transmitter's i_data.
- o_tx_data_we  out  1  write strobe to the transmitter's i_data_we.
- o_tx_frame_commit  out  1  one-cycle pulse: one frame is complete in the buffer.
- o_grant  out  2  one-hot current owner; 0 when idle.
- o_busy  out  1  state != IDLE.
- o_err_len  out  1  sticky length/framing error; cleared only by reset.

## Operation
States: IDLE, CHECK, STREAM, COMMIT.

IDLE
- Pick a winner among asserted i_req_valid.
- On a tie, the round-robin pointer decides (0 after reset).
- Register the winner's grant and its length into len_q.
- Illegal length (len 0 or len > MAX_FRAME_LEN):
  - assert the winner's o_req_ready for one cycle to discard that beat;
  - set o_err_len;
  - move the pointer to the other requester;
  - stay in IDLE.
- Legal length: go to CHECK.

CHECK
- free = BUF_DEPTH - i_tx_data_count, computed at 9 bits unsigned.
- free >= len_q: go to STREAM, clear byte counter cnt_q.
- Otherwise hold CHECK and the grant, with no rotation, so a large frame cannot be starved.

STREAM
- o_req_ready = o_grant, in STREAM only.
- Each handshake: register the byte to o_tx_data, pulse o_tx_data_we, increment cnt_q.
- Frame ends on the handshake where cnt_q+1 == len_q, or where i_req_last = 1, whichever comes first.
- Mismatch sets o_err_len; the frame is still committed:
  - i_req_last early (before len reached): the shorter frame is committed;
  - len reached without i_req_last: the requester's remaining beats are treated as a new frame later.
- Valid low stalls STREAM indefinitely; no timeout.

COMMIT
- Pulse o_tx_frame_commit.
- Move the pointer to the other requester, clear the grant, return to IDLE.

Other rules
- o_tx_data_we never asserts outside a granted frame.
- Bytes from the two requesters never interleave.
- Reset mid-frame: all state and outputs return to their reset values; the pointer returns to 0. Bytes already written stay in the transmitter buffer, and the system resets the transmitter together with this block.

## Timing
- Reset values: o_tx_data=0, o_tx_data_we=0, o_tx_frame_commit=0, o_grant=0, o_busy=0, o_err_len=0, o_req_ready=0. The pointer resets to 0.
- All outputs are registered except o_req_ready, which is decoded from registered state and grant.
- Request valid in IDLE at cycle 0: o_grant visible at cycle 1 (CHECK), STREAM at cycle 2 at the earliest.
- Byte accepted in cycle k appears on o_tx_data with o_tx_data_we=1 in cycle k+1. Throughput is 1 byte/cycle.
- Final byte accepted in cycle k: COMMIT in cycle k+1, o_tx_frame_commit=1 in cycle k+2, IDLE in cycle k+2.
- Next grant visible at k+3 at the earliest. By the CHECK cycle that follows it, the final byte is already reflected in i_tx_data_count.

## Structure
- Package m_tx_pkg: state enum (IDLE/CHECK/STREAM/COMMIT) and the BUF_DEPTH/MAX_FRAME_LEN defaults, shared with the transmitter.
- One sub-module, m_rr_arbiter2: two-request round-robin pick with a pointer-advance input. The FSM and datapath stay in the top module.

## Test plan
- Requester 0 alone, len=3, bytes A1 A2 A3 with last on A3, count=0: three o_tx_data_we pulses carrying A1,A2,A3; one commit two cycles after A3 is accepted; o_err_len=0.
- Both requesters valid at reset, len=2 each: requester 0 granted first, then requester 1; output byte order R0,R0,R1,R1; two commits.
- count=250, len=10: holds CHECK with o_req_ready=0. Drop count to 246: STREAM on the next cycle.
- len=3 with last on the 2nd byte: two bytes written, commit, o_err_len=1. Also len=0: one beat discarded, o_err_len=1, no write, no commit.
- Requester 0 valid low for 5 cycles mid-frame: no writes during the stall, and no requester-1 bytes written during it.
- i_rst=1 during STREAM: the next cycle shows all outputs 0 and o_grant=0. After reset release, requester 0 wins the tie.
